// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus layouts,
// mem_control fields, access sizes and FSM states.
package mem_stage_pkg;

  localparam int EXE_MEM_W = 163;

  localparam int MC_LOAD  = 4;
  localparam int MC_STORE = 3;
  localparam int MC_SZ_HI = 2;
  localparam int MC_SZ_LO = 1;
  localparam int MC_SIGN  = 0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] WBYTES_FULL = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_DRAIN
  } mem_state_e;

  typedef struct packed {
    logic        inst_jbr;
    logic [4:0]  mem_control;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        brk;
    logic        ov_ex;
    logic        ri_ex;
    logic        eret;
    logic        wen;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;
    logic [3:0]  rf_wbytes;
  } exe_mem_t;

  typedef struct packed {
    logic        wen_final;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        brk;
    logic        ov_ex;
    logic        ri_ex;
    logic        eret;
    logic        adel;
    logic        ades;
    logic [31:0] pc;
    logic [3:0]  rf_wbytes;
    logic [31:0] badvaddr;
  } mem_wb_t;

  // Width follows the field list so WB unpacks it field for field.
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/mem_align.sv
// Store strobe/data lane placement and load byte/half
// extraction with sign or zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic        full_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  assign byte_w = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_w = addr_i[1] ? rdata_i[31:16]
                            : rdata_i[15:0];

  always_comb begin
    wstrb_o    = 4'b1111;
    wdata_o    = store_data_i;
    ldata_o    = rdata_i;
    misalign_o = 1'b0;
    unique case (size_i)
      SZ_BYTE: begin
        wstrb_o = 4'b0001 << addr_i;
        wdata_o = {4{store_data_i[7:0]}};
        ldata_o = {{24{sign_i & byte_w[7]}},
                   byte_w};
      end
      SZ_HALF: begin
        wstrb_o = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
        ldata_o = {{16{sign_i & half_w[15]}},
                   half_w};
        misalign_o = addr_i[0];
      end
      default: begin
        misalign_o = full_i & (addr_i != 2'b00);
      end
    endcase
    // LWL/LWR: WB merges the whole word via rf_wbytes.
    if (!full_i) ldata_o = rdata_i;
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-bus handshake FSM, alignment
// checks, load result assembly and forwarding outputs.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MEM_valid,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
  input  logic                 WB_allow_in,
  input  logic                 cancel,
  output logic                 data_req,
  output logic                 data_wr,
  output logic [3:0]           data_wstrb,
  output logic [31:0]          data_addr,
  output logic [31:0]          data_wdata,
  input  logic                 data_addr_ok,
  input  logic                 data_data_ok,
  input  logic [31:0]          data_rdata,
  output logic                 MEM_over,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  output logic [4:0]           MEM_wdest,
  output logic                 MEM_load,
  output logic                 MEM_hi_write,
  output logic                 MEM_lo_write,
  output logic [31:0]          MEM_hi_data,
  output logic [31:0]          MEM_lo_data,
  output logic                 MEM_mfhi,
  output logic                 MEM_mflo
);

  exe_mem_t   ex;
  mem_wb_t    wb;
  mem_state_e state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic        load, store, full, exc_in;
  logic        misalign, adel, ades, go_mem;
  logic [3:0]  wstrb;
  logic [31:0] wdata, ldata;
  logic        fwd;
  logic        unused;

  assign ex     = EXE_MEM_bus_r;
  assign unused = ex.inst_jbr;

  assign load   = ex.mem_control[MC_LOAD];
  assign store  = ex.mem_control[MC_STORE];
  assign full   = ex.rf_wbytes == WBYTES_FULL;
  assign exc_in = ex.syscall | ex.brk
                | ex.ov_ex | ex.ri_ex;

  mem_align u_align (
    .addr_i       (ex.exe_result[1:0]),
    .size_i       (ex.mem_control[MC_SZ_HI:MC_SZ_LO]),
    .sign_i       (ex.mem_control[MC_SIGN]),
    .full_i       (full),
    .store_data_i (ex.store_data),
    .rdata_i      (rdata_q),
    .wstrb_o      (wstrb),
    .wdata_o      (wdata),
    .ldata_o      (ldata),
    .misalign_o   (misalign)
  );

  assign adel   = load & misalign;
  assign ades   = store & misalign;
  assign go_mem = MEM_valid & (load | store)
                & ~misalign & ~exc_in & ~cancel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    data_req = 1'b0;
    MEM_over = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (MEM_valid)
          state_d = go_mem ? S_ADDR : S_DONE;
      end
      S_ADDR: begin
        data_req = 1'b1;
        // An accepted address owes one response even if flushed.
        if (data_addr_ok)
          state_d = cancel ? S_DRAIN : S_DATA;
        else if (cancel)
          state_d = S_IDLE;
      end
      S_DATA: begin
        if (cancel) begin
          state_d = data_data_ok ? S_IDLE : S_DRAIN;
        end else if (data_data_ok) begin
          rdata_d = data_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        MEM_over = 1'b1;
        if (WB_allow_in) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_wr    = store;
  assign data_wstrb = store ? wstrb : 4'b0000;
  assign data_wdata = wdata;
  assign data_addr  = full ? ex.exe_result
                    : {ex.exe_result[31:2], 2'b00};

  always_comb begin
    wb            = '0;
    wb.wen_final  = ex.wen & ~ex.ov_ex & ~adel;
    wb.rf_wdest   = ex.rf_wdest;
    wb.mem_result = load ? ldata : ex.exe_result;
    wb.lo_result  = ex.lo_result;
    wb.hi_write   = ex.hi_write;
    wb.lo_write   = ex.lo_write;
    wb.mtc0       = ex.mtc0;
    wb.mfc0       = ex.mfc0;
    wb.cp0r_addr  = ex.cp0r_addr;
    wb.syscall    = ex.syscall;
    wb.brk        = ex.brk;
    wb.ov_ex      = ex.ov_ex;
    wb.ri_ex      = ex.ri_ex;
    wb.eret       = ex.eret;
    wb.adel       = adel;
    wb.ades       = ades;
    wb.pc         = ex.pc;
    wb.rf_wbytes  = ex.rf_wbytes;
    wb.badvaddr   = ex.exe_result;
  end

  assign MEM_WB_bus = wb;

  assign fwd          = MEM_valid & ~reset;
  assign MEM_wdest    = fwd ? ex.rf_wdest : 5'd0;
  assign MEM_load     = fwd & load;
  assign MEM_hi_write = fwd & ex.hi_write;
  assign MEM_lo_write = fwd & ex.lo_write;
  assign MEM_hi_data  = fwd ? ex.exe_result : 32'd0;
  assign MEM_lo_data  = fwd ? ex.lo_result : 32'd0;
  assign MEM_mfhi     = fwd & ex.mfhi;
  assign MEM_mflo     = fwd & ex.mflo;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage with a field-level
// reference model and a scripted data-bus responder.
module tb_mem_stage;

  localparam int WBW = 157;

  logic           clk = 1'b0;
  logic           reset;
  logic           MEM_valid;
  logic [162:0]   EXE_MEM_bus_r;
  logic           WB_allow_in;
  logic           cancel;
  logic           data_req, data_wr;
  logic [3:0]     data_wstrb;
  logic [31:0]    data_addr, data_wdata;
  logic           data_addr_ok, data_data_ok;
  logic [31:0]    data_rdata;
  logic           MEM_over;
  logic [WBW-1:0] MEM_WB_bus;
  logic [4:0]     MEM_wdest;
  logic           MEM_load, MEM_hi_write, MEM_lo_write;
  logic [31:0]    MEM_hi_data, MEM_lo_data;
  logic           MEM_mfhi, MEM_mflo;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .MEM_valid     (MEM_valid),
    .EXE_MEM_bus_r (EXE_MEM_bus_r),
    .WB_allow_in   (WB_allow_in),
    .cancel        (cancel),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_wstrb    (data_wstrb),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata),
    .MEM_over      (MEM_over),
    .MEM_WB_bus    (MEM_WB_bus),
    .MEM_wdest     (MEM_wdest),
    .MEM_load      (MEM_load),
    .MEM_hi_write  (MEM_hi_write),
    .MEM_lo_write  (MEM_lo_write),
    .MEM_hi_data   (MEM_hi_data),
    .MEM_lo_data   (MEM_lo_data),
    .MEM_mfhi      (MEM_mfhi),
    .MEM_mflo      (MEM_mflo)
  );

  typedef struct {
    logic        jbr;
    logic [4:0]  mc;
    logic [31:0] sd, ea, lo;
    logic        hiw, low, mfhi, mflo, mtc0, mfc0;
    logic [7:0]  cp0;
    logic        sys, brk, ov, ri, eret, wen;
    logic [4:0]  wd;
    logic [31:0] pc;
    logic [3:0]  wb;
  } ins_t;

  int n_run, n_fail;
  logic [31:0]    last_rd;
  logic [WBW-1:0] obs_wb;
  logic [3:0]     obs_strb;
  logic [31:0]    obs_wdata;

  task automatic chk(string tag, logic [199:0] got,
                     logic [199:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [162:0] pack_bus(ins_t i);
    return {i.jbr, i.mc, i.sd, i.ea, i.lo, i.hiw,
            i.low, i.mfhi, i.mflo, i.mtc0, i.mfc0,
            i.cp0, i.sys, i.brk, i.ov, i.ri, i.eret,
            i.wen, i.wd, i.pc, i.wb};
  endfunction

  function automatic ins_t base();
    ins_t i;
    i.jbr = 1'($urandom);  i.mc = 5'd0;
    i.sd = $urandom;       i.ea = $urandom;
    i.lo = $urandom;       i.hiw = 1'($urandom);
    i.low = 1'($urandom);  i.mfhi = 1'($urandom);
    i.mflo = 1'($urandom); i.mtc0 = 1'($urandom);
    i.mfc0 = 1'($urandom); i.cp0 = 8'($urandom);
    i.sys = 0; i.brk = 0; i.ov = 0; i.ri = 0;
    i.eret = 0;            i.wen = 1'($urandom);
    i.wd = 5'($urandom);   i.pc = $urandom;
    i.wb = 4'hF;
    return i;
  endfunction

  function automatic ins_t mk(logic [4:0] mc,
      logic [31:0] ea, logic [31:0] sd, logic [3:0] wbt);
    ins_t i;
    i = base();
    i.mc = mc; i.ea = ea; i.sd = sd; i.wb = wbt;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    int k;
    logic [1:0] sz;
    logic sg;
    i  = base();
    k  = $urandom_range(0, 9);
    sz = 2'($urandom_range(0, 2));
    sg = 1'($urandom);
    if (k <= 2) begin
      i.mc = {2'b00, sz, sg};
      i.ov = ($urandom_range(0, 3) == 0);
    end else if (k <= 5) i.mc = {2'b10, sz, sg};
    else if (k <= 7) i.mc = {2'b01, sz, sg};
    else if (k == 8) begin
      i.mc = 5'b10100;
      i.wb = 4'($urandom_range(1, 14));
    end else begin
      i.mc  = 5'b10100;
      i.sys = 1'($urandom);
      i.ov  = ~i.sys;
    end
    if ($urandom_range(0, 3) != 0) begin
      if (sz == 2'd1) i.ea[0] = 1'b0;
      if (sz == 2'd2) i.ea[1:0] = 2'b00;
    end
    return i;
  endfunction

  // Expected bus behaviour and WB bundle from the field rules.
  task automatic model(input ins_t i, input logic [31:0] rd,
      output bit is_mem, output logic [31:0] eaddr,
      output logic [3:0] estrb, output logic [31:0] ewd,
      output logic [WBW-1:0] ewb);
    logic ld, st, sg, full, mis, adel, ades, exc;
    logic [1:0]  sz;
    logic [31:0] src, ldv, mres;
    int a;
    ld = i.mc[4]; st = i.mc[3]; sz = i.mc[2:1];
    sg = i.mc[0]; a = int'(i.ea[1:0]);
    full = (i.wb == 4'hF);
    mis  = (sz == 2'd1 && a % 2 == 1)
        || (sz == 2'd2 && full && a != 0);
    adel = ld & mis;
    ades = st & mis;
    exc  = i.sys | i.brk | i.ov | i.ri;
    is_mem = (ld | st) & ~mis & ~exc;
    eaddr  = full ? i.ea : (i.ea & ~32'd3);
    if (sz == 2'd0) begin
      estrb = 4'(1 << a);
      ewd   = {24'd0, i.sd[7:0]} * 32'h0101_0101;
    end else if (sz == 2'd1) begin
      estrb = 4'(3 << (a & 2));
      ewd   = {16'd0, i.sd[15:0]} * 32'h0001_0001;
    end else begin
      estrb = 4'hF;
      ewd   = i.sd;
    end
    src = is_mem ? rd : last_rd;
    if (!full || sz == 2'd2) ldv = src;
    else if (sz == 2'd0) begin
      ldv = (src >> (8 * a)) & 32'hFF;
      if (sg && ldv >= 32'h80) ldv = ldv | 32'hFFFF_FF00;
    end else begin
      ldv = (src >> (8 * (a & 2))) & 32'hFFFF;
      if (sg && ldv >= 32'h8000)
        ldv = ldv | 32'hFFFF_0000;
    end
    mres = ld ? ldv : i.ea;
    ewb = {i.wen & ~i.ov & ~adel, i.wd, mres, i.lo,
           i.hiw, i.low, i.mtc0, i.mfc0, i.cp0, i.sys,
           i.brk, i.ov, i.ri, i.eret, adel, ades, i.pc,
           i.wb, i.ea};
  endtask

  task automatic run_instr(ins_t i, int alat, int dlat,
                           int stall, logic [31:0] rd);
    bit is_mem;
    logic [31:0] eaddr, ewd;
    logic [3:0]  estrb;
    logic [WBW-1:0] ewb;
    model(i, rd, is_mem, eaddr, estrb, ewd, ewb);
    @(negedge clk);
    EXE_MEM_bus_r = pack_bus(i);
    MEM_valid = 1'b1;
    WB_allow_in = 1'b0;
    @(negedge clk);
    chk("fwd_wdest", MEM_wdest, i.wd);
    chk("fwd_load", MEM_load, i.mc[4]);
    chk("fwd_hi", MEM_hi_data, i.ea);
    chk("fwd_lo", MEM_lo_data, i.lo);
    chk("fwd_flags",
        {MEM_hi_write, MEM_lo_write, MEM_mfhi, MEM_mflo},
        {i.hiw, i.low, i.mfhi, i.mflo});
    if (is_mem) begin
      obs_strb  = data_wstrb;
      obs_wdata = data_wdata;
      chk("req", data_req, 1'b1);
      chk("addr", data_addr, eaddr);
      chk("wr", data_wr, i.mc[3]);
      if (i.mc[3]) begin
        chk("wstrb", data_wstrb, estrb);
        chk("wdata", data_wdata, ewd);
      end
      for (int k = 0; k < alat; k++) begin
        @(negedge clk);
        chk("req_hold", data_req, 1'b1);
        chk("addr_hold", data_addr, eaddr);
      end
      data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      chk("req_drop", data_req, 1'b0);
      for (int k = 0; k < dlat; k++) begin
        data_rdata = $urandom;
        @(negedge clk);
        chk("over_wait", MEM_over, 1'b0);
      end
      data_data_ok = 1'b1;
      data_rdata = rd;
      @(negedge clk);
      data_data_ok = 1'b0;
      data_rdata = $urandom;
      last_rd = rd;
    end else begin
      chk("no_req", data_req, 1'b0);
    end
    chk("over", MEM_over, 1'b1);
    chk("wb_bus", MEM_WB_bus, ewb);
    obs_wb = MEM_WB_bus;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("over_hold", MEM_over, 1'b1);
      chk("wb_hold", MEM_WB_bus, ewb);
    end
    WB_allow_in = 1'b1;
    @(negedge clk);
    WB_allow_in = 1'b0;
    MEM_valid = 1'b0;
    chk("over_clr", MEM_over, 1'b0);
  endtask

  task automatic cancel_addr();
    @(negedge clk);
    EXE_MEM_bus_r = pack_bus(mk(5'b10100, 32'h40, 0, 4'hF));
    MEM_valid = 1'b1;
    @(negedge clk);
    chk("ca_req", data_req, 1'b1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    MEM_valid = 1'b0;
    chk("ca_req0", data_req, 1'b0);
    chk("ca_over0", MEM_over, 1'b0);
    @(negedge clk);
    chk("ca_idle", {data_req, MEM_over}, 2'b00);
  endtask

  task automatic cancel_data();
    ins_t nxt;
    nxt = mk(5'b10100, 32'h80, 0, 4'hF);
    nxt.ov = 1'b1;
    @(negedge clk);
    EXE_MEM_bus_r = pack_bus(mk(5'b10100, 32'h50, 0, 4'hF));
    MEM_valid = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    EXE_MEM_bus_r = pack_bus(nxt);
    for (int k = 0; k < 2; k++) begin
      chk("cd_drain_req", data_req, 1'b0);
      chk("cd_drain_over", MEM_over, 1'b0);
      @(negedge clk);
    end
    chk("cd_drain_over", MEM_over, 1'b0);
    data_data_ok = 1'b1;
    data_rdata = 32'hDEAD_BEEF;
    MEM_valid = 1'b0;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk("cd_after", {data_req, MEM_over}, 2'b00);
    run_instr(nxt, 0, 0, 0, 32'h0);
    run_instr(mk(5'b10100, 32'h90, 0, 4'hF),
              1, 1, 0, $urandom);
  endtask

  task automatic cancel_same();
    @(negedge clk);
    EXE_MEM_bus_r = pack_bus(mk(5'b10100, 32'h60, 0, 4'hF));
    MEM_valid = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b1;
    cancel = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    cancel = 1'b0;
    chk("cs_req", data_req, 1'b0);
    chk("cs_over", MEM_over, 1'b0);
    @(negedge clk);
    chk("cs_drain", {data_req, MEM_over}, 2'b00);
    data_data_ok = 1'b1;
    data_rdata = $urandom;
    MEM_valid = 1'b0;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk("cs_after", {data_req, MEM_over}, 2'b00);
  endtask

  task automatic reset_hold();
    ins_t e;
    e = mk(5'b10100, 32'h100, 0, 4'hF);
    e.sys = 1'b1;
    @(negedge clk);
    EXE_MEM_bus_r = pack_bus(mk(5'b00000, $urandom, 0, 4'hF));
    MEM_valid = 1'b1;
    @(negedge clk);
    chk("rh_over", MEM_over, 1'b1);
    @(negedge clk);
    chk("rh_over2", MEM_over, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rh_async_over", MEM_over, 1'b0);
    chk("rh_async_req", data_req, 1'b0);
    chk("rh_fwd", {MEM_wdest, MEM_hi_data}, 37'd0);
    @(negedge clk);
    reset = 1'b0;
    MEM_valid = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
    chk("rh_idle", MEM_over, 1'b0);
    run_instr(e, 0, 0, 0, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    n_run = 0; n_fail = 0; last_rd = 32'h0;
    reset = 1'b1; MEM_valid = 1'b1; WB_allow_in = 1'b0;
    cancel = 1'b0; data_addr_ok = 1'b0;
    data_data_ok = 1'b0; data_rdata = 32'h0;
    EXE_MEM_bus_r = pack_bus(mk(5'b10101, 32'h1000, 0, 4'hF));
    repeat (2) @(negedge clk);
    chk("rst_over", MEM_over, 1'b0);
    chk("rst_req", data_req, 1'b0);
    chk("rst_fwd", {MEM_wdest, MEM_load, MEM_hi_data,
                    MEM_lo_data}, 70'd0);
    reset = 1'b0;
    MEM_valid = 1'b0;
    @(negedge clk);
    chk("idle_fwd", {MEM_hi_data, MEM_load}, 33'd0);
    chk("idle_over", MEM_over, 1'b0);

    run_instr(mk(5'b10001, 32'h1003, 0, 4'hF),
              0, 1, 0, 32'h80FF_1234);
    chk("lb_result", obs_wb[150:119], 32'hFFFF_FF80);
    run_instr(mk(5'b01010, 32'h2002, 32'h0000_ABCD, 4'hF),
              0, 0, 0, $urandom);
    chk("sh_strb", obs_strb, 4'b1100);
    chk("sh_wdata", obs_wdata, 32'hABCD_ABCD);
    run_instr(mk(5'b10100, 32'h3001, 0, 4'hF),
              0, 0, 0, 32'h0);
    chk("lw_adel", obs_wb[69], 1'b1);
    chk("lw_badv", obs_wb[31:0], 32'h3001);
    run_instr(mk(5'b10100, 32'h4000, 0, 4'hF),
              5, 2, 0, 32'h1234_5678);
    run_instr(mk(5'b00000, 32'h77, 0, 4'hF),
              0, 0, 2, 32'h0);
    cancel_addr();
    cancel_data();
    cancel_same();
    reset_hold();

    for (int n = 0; n < 60; n++)
      run_instr(rnd_ins(), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
